// File: rtl/johnson_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_pkg
//  Description : Shared types and helpers for the Johnson-ring sequencer.
//                Holds the controller state enum, the direction encodings
//                and the phase-index width function.
//  Revision    : 1.0  initial release
// ============================================================================
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Number of bits needed to index every phase of a 2*width sequence.
  function automatic int ph_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_cmd_if
//  Description : Step-command valid/ready channel between the requester
//                (master) and the Johnson sequencer (slave).
//  Signals     : cmd_valid  request from master
//                cmd_ready  sequencer can accept a command
//                cmd_steps  number of ring advances (STEP_W bits)
//                cmd_dir    0 = forward, 1 = reverse
//  Revision    : 1.0  initial release
// ============================================================================
interface johnson_cmd_if #(
  parameter int STEP_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/johnson_seq_ctrl_core.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_core
//  Description : Johnson ring register plus matching binary phase index.
//                Advances one position per cycle while i_en is high, in the
//                direction given by i_dir.
//                Build option JOHNSON_SELF_CORRECT_EN: checks the ring for a
//                legal Johnson code every cycle; an illegal code clears ring
//                and phase next cycle and sets a sticky error flag.
//  Ports       : clk      system clock
//                rstn     asynchronous active-low reset
//                i_en     advance one step this cycle
//                i_dir    0 = forward, 1 = reverse
//                o_out    Johnson code
//                o_phase  binary phase index 0..2*WIDTH-1
//                o_fault  illegal code seen this cycle (self-correct only)
//                o_err    sticky illegal-code flag (self-correct only)
//  Revision    : 1.0  initial release
// ============================================================================
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PH_W  = ph_width(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             i_en,
  input  wire logic             i_dir,
  output logic      [WIDTH-1:0] o_out,
  output logic      [PH_W-1:0]  o_phase,
  output logic                  o_fault,
  output logic                  o_err
);

  localparam logic [PH_W-1:0] c_ph_max = PH_W'(2 * WIDTH - 1);

  logic [WIDTH-1:0] r_ring;
  logic [PH_W-1:0]  r_phase;
  logic             w_fault;

`ifdef JOHNSON_SELF_CORRECT_EN
  // A legal Johnson code (0*1* or 1*0*) has at most one place where
  // neighbouring bits differ; the wrap-around pair is not considered.
  logic [WIDTH-2:0] w_edges;
  logic             r_err;

  assign w_edges = r_ring[WIDTH-1:1] ^ r_ring[WIDTH-2:0];
  assign w_fault = ($countones(w_edges) > 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_fault) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_fault = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ring  <= '0;
      r_phase <= '0;
    end else if (w_fault) begin
      // Correction takes priority over any requested step.
      r_ring  <= '0;
      r_phase <= '0;
    end else if (i_en) begin
      if (i_dir == DIR_FWD) begin
        r_ring  <= {r_ring[WIDTH-2:0], ~r_ring[WIDTH-1]};
        r_phase <= (r_phase == c_ph_max) ? '0 : r_phase + 1'b1;
      end else begin
        r_ring  <= {~r_ring[0], r_ring[WIDTH-1:1]};
        r_phase <= (r_phase == '0) ? c_ph_max : r_phase - 1'b1;
      end
    end
  end

  assign o_out   = r_ring;
  assign o_phase = r_phase;
  assign o_fault = w_fault;

endmodule
`default_nettype wire

// File: rtl/johnson_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : johnson_seq_ctrl
//  Description : Command-driven sequencer stepping a WIDTH-bit Johnson ring a
//                requested number of phases in a requested direction, with
//                hold, abort and a one-cycle done pulse.
//                Build option JOHNSON_SELF_CORRECT_EN: illegal ring codes are
//                cleared and reported on err; otherwise err is tied low.
//  Ports       : clk    system clock, rising edge
//                rstn   asynchronous active-low reset
//                cmd    command channel (johnson_cmd_if.slave)
//                hold   freeze stepping while high
//                abort  terminate the running command (no done pulse)
//                out    Johnson code
//                phase  binary phase index
//                busy   command in progress
//                done   one-cycle completion pulse
//                err    sticky illegal-code flag
//  Revision    : 1.0  initial release
// ============================================================================
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  wire logic                        clk,
  input  wire logic                        rstn,
  johnson_cmd_if.slave                     cmd,
  input  wire logic                        hold,
  input  wire logic                        abort,
  output logic [WIDTH-1:0]                 out,
  output logic [ph_width(WIDTH)-1:0]       phase,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int PH_W = ph_width(WIDTH);

  state_t            r_state;
  logic [STEP_W-1:0] r_rem;
  logic              r_dir;
  logic              r_busy;
  logic              r_done;
  logic              r_cmd_ready;
  logic              w_step;
  logic              w_fault;

  // abort outranks both hold and the final step.
  assign w_step = (r_state == RUN) && !abort && !hold;

  johnson_core #(
    .WIDTH (WIDTH),
    .PH_W  (PH_W)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (w_step),
    .i_dir   (r_dir),
    .o_out   (out),
    .o_phase (phase),
    .o_fault (w_fault),
    .o_err   (err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_dir       <= DIR_FWD;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else if (w_fault) begin
      // Ring is being cleared by the core; drop any command silently.
      r_state     <= IDLE;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (cmd.cmd_valid && r_cmd_ready) begin
            r_dir       <= cmd.cmd_dir;
            r_rem       <= cmd.cmd_steps;
            r_cmd_ready <= 1'b0;
            if (cmd.cmd_steps == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end else if (!hold) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == STEP_W'(1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        DONE: begin
          r_state     <= IDLE;
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign cmd.cmd_ready = r_cmd_ready;

endmodule
`default_nettype wire
